// File: rtl/raw_waw_issue_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_types (package)
// Description : Shared types and constants for the issue-stage RAW/WAW
//               scoreboard: sizing constants, the issue request struct and
//               the latency clamp helper.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_types;

    localparam int SB_NREGS   = 32;
    localparam int SB_ADDR_W  = $clog2(SB_NREGS);
    localparam int SB_MAX_LAT = 8;
    localparam int SB_CNT_W   = $clog2(SB_MAX_LAT + 1);

    typedef struct packed {
        logic [SB_ADDR_W-1:0] rs1;
        logic [SB_ADDR_W-1:0] rs2;
        logic [SB_ADDR_W-1:0] rs3;
        logic [2:0]           rs_use;      // {rs3, rs2, rs1}
        logic [2:0]           rs_fp;       // {rs3, rs2, rs1}
        logic [SB_ADDR_W-1:0] rd;
        logic                 reg_write;
        logic                 FP_reg_write;
        logic [SB_CNT_W-1:0]  lat;
    } sb_issue_t;

    // Out-of-range latencies are illegal; hardware still behaves sanely by
    // pulling them into 1..SB_MAX_LAT.
    function automatic logic [SB_CNT_W-1:0] sb_clamp_lat(input logic [SB_CNT_W-1:0] lat);
        if (lat == '0) begin
            return SB_CNT_W'(1);
        end
        if (lat > SB_CNT_W'(SB_MAX_LAT)) begin
            return SB_CNT_W'(SB_MAX_LAT);
        end
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/raw_waw_issue_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : raw_waw_issue_scoreboard_if
// Description : Issue handshake between decode (master) and the scoreboard
//               (slave). Signal suffixes are relative to the scoreboard.
//               issue_valid_i / issue_ready_o : valid/ready handshake
//               rs1_i..rs3_i, rs_use_i, rs_fp_i : source operands
//               rd_i, reg_write_i, FP_reg_write_i, lat_i : destination write
// Revision    : 1.0 - initial release
// ============================================================================
interface raw_waw_issue_scoreboard_if #(
    parameter int ADDR_W = riscv_types::SB_ADDR_W,
    parameter int CNT_W  = riscv_types::SB_CNT_W
) ();

    logic              issue_valid_i;
    logic              issue_ready_o;
    logic [ADDR_W-1:0] rs1_i;
    logic [ADDR_W-1:0] rs2_i;
    logic [ADDR_W-1:0] rs3_i;
    logic [2:0]        rs_use_i;
    logic [2:0]        rs_fp_i;
    logic [ADDR_W-1:0] rd_i;
    logic              reg_write_i;
    logic              FP_reg_write_i;
    logic [CNT_W-1:0]  lat_i;

    modport master (
        output issue_valid_i, rs1_i, rs2_i, rs3_i, rs_use_i, rs_fp_i,
               rd_i, reg_write_i, FP_reg_write_i, lat_i,
        input  issue_ready_o
    );

    modport slave (
        input  issue_valid_i, rs1_i, rs2_i, rs3_i, rs_use_i, rs_fp_i,
               rd_i, reg_write_i, FP_reg_write_i, lat_i,
        output issue_ready_o
    );

endinterface
`default_nettype wire

// File: rtl/raw_waw_issue_scoreboard_wb_slot.sv
`default_nettype none
// ============================================================================
// Module      : sb_wb_slot_reserve
// Description : Writeback-port reservation shift register. Bit k of the
//               post-shift view means the shared writeback port is taken
//               k+1 cycles after the current edge.
//               clk, reset        : clock, synchronous active-high reset
//               clear_i           : drop all reservations (flush)
//               reserve_i         : reserve slot for reserve_lat_i
//               query_lat_i       : latency of the candidate instruction
//               query_busy_o      : candidate's slot already reserved
// Revision    : 1.0 - initial release
// ============================================================================
module sb_wb_slot_reserve #(
    parameter int MAX_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             reserve_i,
    input  logic [CNT_W-1:0] reserve_lat_i,
    input  logic [CNT_W-1:0] query_lat_i,
    output logic             query_busy_o
);

    localparam logic [MAX_LAT-1:0] c_one = MAX_LAT'(1);

    logic [MAX_LAT-1:0] r_slot;
    logic [MAX_LAT-1:0] w_shifted;
    logic [MAX_LAT-1:0] w_reserve_mask;
    logic [MAX_LAT-1:0] w_query_mask;

    // The hazard query is made in the same post-shift frame the reservation
    // is written in, so two instructions landing on one cycle always collide.
    assign w_shifted      = r_slot >> 1;
    assign w_reserve_mask = c_one << (reserve_lat_i - CNT_W'(1));
    assign w_query_mask   = c_one << (query_lat_i - CNT_W'(1));
    assign query_busy_o   = |(w_shifted & w_query_mask);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            r_slot <= '0;
        end else if (reserve_i) begin
            r_slot <= w_shifted | w_reserve_mask;
        end else begin
            r_slot <= w_shifted;
        end
    end

endmodule
`default_nettype wire

// File: rtl/raw_waw_issue_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : raw_waw_issue_scoreboard
// Description : Issue-stage scoreboard in front of the multi-cycle unit
//               pipes. Per-register countdowns for INT and FP destinations
//               hold issue on RAW, WAW and shared-writeback-slot hazards.
//               clk, reset      : clock, synchronous active-high reset
//               issue           : issue handshake + operands (slave modport)
//               flush_i         : clears all pending state, blocks issue
//               stall_raw_o/stall_waw_o/stall_wb_o : hazard causes (comb)
//               busy_int_o/busy_fp_o : per-register pending-write masks
//               Optional macro RAW_BYPASS_EN: a source whose countdown is 1
//               is served by the writeback bypass and does not stall.
// Revision    : 1.0 - initial release
// ============================================================================
module raw_waw_issue_scoreboard
    import riscv_types::*;
#(
    parameter int NREGS   = SB_NREGS,
    parameter int ADDR_W  = SB_ADDR_W,
    parameter int MAX_LAT = SB_MAX_LAT,
    parameter int CNT_W   = SB_CNT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    raw_waw_issue_scoreboard_if.slave   issue,
    input  logic                        flush_i,
    output logic                        stall_raw_o,
    output logic                        stall_waw_o,
    output logic                        stall_wb_o,
    output logic [NREGS-1:0]            busy_int_o,
    output logic [NREGS-1:0]            busy_fp_o
);

`ifdef RAW_BYPASS_EN
    localparam logic [CNT_W-1:0] c_raw_thresh = CNT_W'(1);
`else
    localparam logic [CNT_W-1:0] c_raw_thresh = CNT_W'(0);
`endif

    logic [CNT_W-1:0]  r_cnt_int [NREGS];
    logic [CNT_W-1:0]  r_cnt_fp  [NREGS];

    sb_issue_t         w_req;
    logic [ADDR_W-1:0] w_src [3];
    logic [CNT_W-1:0]  w_lat;
    logic              w_wr_int;
    logic              w_wr_fp;
    logic              w_wr_any;
    logic [CNT_W-1:0]  w_tgt_cnt;
    logic              w_raw;
    logic              w_waw;
    logic              w_wb;
    logic              w_slot_busy;
    logic              w_ready;
    logic              w_fire;

    assign w_req.rs1          = issue.rs1_i;
    assign w_req.rs2          = issue.rs2_i;
    assign w_req.rs3          = issue.rs3_i;
    assign w_req.rs_use       = issue.rs_use_i;
    assign w_req.rs_fp        = issue.rs_fp_i;
    assign w_req.rd           = issue.rd_i;
    assign w_req.reg_write    = issue.reg_write_i;
    assign w_req.FP_reg_write = issue.FP_reg_write_i;
    assign w_req.lat          = issue.lat_i;

    assign w_src[0] = w_req.rs1;
    assign w_src[1] = w_req.rs2;
    assign w_src[2] = w_req.rs3;

    assign w_lat = sb_clamp_lat(w_req.lat);

    // FP wins when both write enables are set; INT x0 writes are dropped.
    assign w_wr_fp  = w_req.FP_reg_write;
    assign w_wr_int = w_req.reg_write && !w_req.FP_reg_write && (w_req.rd != '0);
    assign w_wr_any = w_wr_fp || w_wr_int;

    always_comb begin
        w_raw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (w_req.rs_use[k]) begin
                if (w_req.rs_fp[k]) begin
                    if (r_cnt_fp[w_src[k]] > c_raw_thresh) begin
                        w_raw = 1'b1;
                    end
                end else if (w_src[k] != '0) begin
                    if (r_cnt_int[w_src[k]] > c_raw_thresh) begin
                        w_raw = 1'b1;
                    end
                end
            end
        end
    end

    // An older write still at least lat_i away would land at or after ours.
    assign w_tgt_cnt = w_wr_fp ? r_cnt_fp[w_req.rd] : r_cnt_int[w_req.rd];
    assign w_waw     = w_wr_any && (w_tgt_cnt >= w_lat);
    assign w_wb      = w_wr_any && w_slot_busy;

    assign w_ready = !(w_raw || w_waw || w_wb) && !flush_i;
    assign w_fire  = issue.issue_valid_i && w_ready;

    assign issue.issue_ready_o = w_ready;
    assign stall_raw_o         = w_raw;
    assign stall_waw_o         = w_waw;
    assign stall_wb_o          = w_wb;

    sb_wb_slot_reserve #(
        .MAX_LAT (MAX_LAT),
        .CNT_W   (CNT_W)
    ) u_wb_slot (
        .clk           (clk),
        .reset         (reset),
        .clear_i       (flush_i),
        .reserve_i     (w_fire && w_wr_any),
        .reserve_lat_i (w_lat),
        .query_lat_i   (w_lat),
        .query_busy_o  (w_slot_busy)
    );

    // A new write reloads its counter, overriding that register's decrement.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            for (int i = 0; i < NREGS; i++) begin
                r_cnt_int[i] <= '0;
                r_cnt_fp[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (w_fire && w_wr_int && (w_req.rd == ADDR_W'(i))) begin
                    r_cnt_int[i] <= w_lat;
                end else if (r_cnt_int[i] != '0) begin
                    r_cnt_int[i] <= r_cnt_int[i] - CNT_W'(1);
                end
                if (w_fire && w_wr_fp && (w_req.rd == ADDR_W'(i))) begin
                    r_cnt_fp[i] <= w_lat;
                end else if (r_cnt_fp[i] != '0) begin
                    r_cnt_fp[i] <= r_cnt_fp[i] - CNT_W'(1);
                end
            end
        end
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : g_busy
        assign busy_int_o[gi] = (r_cnt_int[gi] != '0);
        assign busy_fp_o[gi]  = (r_cnt_fp[gi] != '0);
    end

    a_lat_legal: assert property (@(posedge clk) disable iff (reset)
        issue.issue_valid_i |-> ((w_req.lat != '0) && (w_req.lat <= CNT_W'(MAX_LAT))));

    a_single_write: assert property (@(posedge clk) disable iff (reset)
        issue.issue_valid_i |-> !(w_req.reg_write && w_req.FP_reg_write));

endmodule
`default_nettype wire
